// File: rtl/dqs_group_scan_ctrl.sv
// ---------------------------------------------------------------------------
// dqs_group_scan_ctrl
//
// Scan sequencer for the DDR PHY per-lane debug group mux. It walks the lane
// select through every DQS lane and waits for the registered mux output to
// settle. It then captures the lane's error flags and slice state, and
// reports each lane on a valid/ready channel. A sticky per-lane error mask
// and a saturating count of completed scans are kept alongside.
//
// Ports:
//   ddrphy_sysclk          clock
//   ddrphy_rst_n           synchronous active-low reset
//   scan_start             single-cycle pulse, starts a scan (only from IDLE)
//   scan_continuous        level, restart from lane 0 after each scan
//   clr_sticky             pulse, clears err_lane_mask
//   grp_sel[31:0]          lane select to the group mux
//   err_flag_out_group     selected-lane error flags from the mux (64 bits)
//   dbg_slice_state_group  selected-lane slice state from the mux (22 bits)
//   scan_busy              high while the scan FSM is outside IDLE
//   scan_done              one-cycle pulse at the end of every full scan
//   lane_err_valid/ready   report handshake
//   lane_err_idx           lane index of the report
//   lane_err_popcnt        number of set error flags (0..64)
//   lane_err_state         captured slice state
//   err_lane_mask[8:0]     sticky bit per lane that reported errors
//   scan_count             completed scans, saturating
//
// Build option:
//   SCAN_SKIP_CLEAN_EN  when defined, lanes with a zero popcount skip the
//                       report handshake (capture registers still update).
// ---------------------------------------------------------------------------
module dqs_group_scan_ctrl #(
    parameter int MEM_DQS_WIDTH = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 ddrphy_sysclk,
    input  logic                 ddrphy_rst_n,
    input  logic                 scan_start,
    input  logic                 scan_continuous,
    input  logic                 clr_sticky,
    output logic [31:0]          grp_sel,
    input  logic [63:0]          err_flag_out_group,
    input  logic [21:0]          dbg_slice_state_group,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic                 lane_err_valid,
    input  logic                 lane_err_ready,
    output logic [3:0]           lane_err_idx,
    output logic [6:0]           lane_err_popcnt,
    output logic [21:0]          lane_err_state,
    output logic [8:0]           err_lane_mask,
    output logic [CNT_WIDTH-1:0] scan_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SETTLE,
        CAPTURE,
        REPORT,
        NEXT,
        DONE
    } state_t;

    localparam logic [3:0] LAST_IDX    = 4'(MEM_DQS_WIDTH - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    // Only lanes that exist may ever appear in the sticky mask.
    localparam logic [8:0] LANE_MASK   = 9'((1 << MEM_DQS_WIDTH) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic [6:0]  cap_popcnt;
    logic [8:0]  lane_bit;
    logic [8:0]  mask_next;

    // Population count of the error flags currently presented by the mux.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first,
        // otherwise an incomplete path infers a latch.
        cap_popcnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cap_popcnt = cap_popcnt + {6'd0, err_flag_out_group[i]};
        end
    end

    assign lane_bit = 9'd1 << idx;

    // Clear and set can land on the same edge: the clear acts first, so the
    // freshly captured lane survives while all older bits drop.
    always_comb begin
        mask_next = clr_sticky ? 9'd0 : err_lane_mask;
        if ((state == CAPTURE) && (cap_popcnt != 7'd0)) begin
            mask_next = mask_next | lane_bit;
        end
        mask_next = mask_next & LANE_MASK;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_start) state_next = SEL;
            SEL:     state_next = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_next = CAPTURE;
`ifdef SCAN_SKIP_CLEAN_EN
            CAPTURE: state_next = (cap_popcnt == 7'd0) ? NEXT : REPORT;
`else
            CAPTURE: state_next = REPORT;
`endif
            REPORT:  if (lane_err_ready) state_next = NEXT;
            NEXT:    state_next = (idx == LAST_IDX) ? DONE : SEL;
            DONE:    state_next = scan_continuous ? SEL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ddrphy_sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!ddrphy_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs. Status outputs are decoded from the
    // next state so they line up with the state register without a lag.
    always_ff @(posedge ddrphy_sysclk) begin
        if (!ddrphy_rst_n) begin
            idx             <= 4'd0;
            settle_cnt      <= 4'd0;
            grp_sel         <= 32'd0;
            scan_busy       <= 1'b0;
            scan_done       <= 1'b0;
            lane_err_valid  <= 1'b0;
            lane_err_idx    <= 4'd0;
            lane_err_popcnt <= 7'd0;
            lane_err_state  <= 22'd0;
            err_lane_mask   <= 9'd0;
            scan_count      <= '0;
        end else begin
            scan_busy      <= (state_next != IDLE);
            scan_done      <= (state_next == DONE);
            lane_err_valid <= (state_next == REPORT);
            err_lane_mask  <= mask_next;

            case (state)
                IDLE: begin
                    if (scan_start) idx <= 4'd0;
                end
                SEL: begin
                    grp_sel    <= {28'd0, idx};
                    settle_cnt <= SETTLE_INIT;
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CAPTURE: begin
                    lane_err_popcnt <= cap_popcnt;
                    lane_err_state  <= dbg_slice_state_group;
                    lane_err_idx    <= idx;
                end
                NEXT: begin
                    if (idx != LAST_IDX) idx <= idx + 4'd1;
                end
                DONE: begin
                    if (scan_count != {CNT_WIDTH{1'b1}}) begin
                        scan_count <= scan_count + CNT_ONE;
                    end
                    if (scan_continuous) idx <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dqs_group_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dqs_group_scan_ctrl
//
// Bench for dqs_group_scan_ctrl. A registered group-mux model drives the
// selected lane's flags/state from per-lane tables. A transaction-level
// model predicts, per scan, the ordered lane reports, their popcounts and
// states, the sticky mask, the busy window, the completed-scan count and
// the per-lane report spacing. It is compared against the DUT on every
// falling edge. Directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_dqs_group_scan_ctrl;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_start = 1'b0;
    logic          scan_continuous = 1'b0;
    logic          clr_sticky = 1'b0;
    logic [31:0]   grp_sel;
    logic [63:0]   err_flag_out_group = '0;
    logic [21:0]   dbg_slice_state_group = '0;
    logic          scan_busy;
    logic          scan_done;
    logic          lane_err_valid;
    logic          lane_err_ready = 1'b1;
    logic [3:0]    lane_err_idx;
    logic [6:0]    lane_err_popcnt;
    logic [21:0]   lane_err_state;
    logic [8:0]    err_lane_mask;
    logic [CW-1:0] scan_count;

    always #5 clk = ~clk;

    dqs_group_scan_ctrl #(
        .MEM_DQS_WIDTH(W),
        .SETTLE_CYCLES(S),
        .CNT_WIDTH    (CW)
    ) dut (
        .ddrphy_sysclk        (clk),
        .ddrphy_rst_n         (rst_n),
        .scan_start           (scan_start),
        .scan_continuous      (scan_continuous),
        .clr_sticky           (clr_sticky),
        .grp_sel              (grp_sel),
        .err_flag_out_group   (err_flag_out_group),
        .dbg_slice_state_group(dbg_slice_state_group),
        .scan_busy            (scan_busy),
        .scan_done            (scan_done),
        .lane_err_valid       (lane_err_valid),
        .lane_err_ready       (lane_err_ready),
        .lane_err_idx         (lane_err_idx),
        .lane_err_popcnt      (lane_err_popcnt),
        .lane_err_state       (lane_err_state),
        .err_lane_mask        (err_lane_mask),
        .scan_count           (scan_count)
    );

    // Per-lane contents seen through the mux; only changed while idle.
    logic [63:0] lane_flags [16];
    logic [21:0] lane_state [16];

    // Group mux: one registered cycle from select to data.
    always @(posedge clk) begin
        err_flag_out_group    <= lane_flags[grp_sel[3:0]];
        dbg_slice_state_group <= lane_state[grp_sel[3:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model state ----------------
    int          cyc = 0;
    int          exp_idx = 0;      // next lane expected to report in this scan
    int          hs_cyc = 0;
    bit          have_hs = 1'b0;
    int          n_reports = 0;
    logic [8:0]  m_mask = '0;
    logic [CW-1:0] m_count = '0;
    bit          m_busy = 1'b0;
    // Inputs/outputs observed on the previous falling edge, i.e. what the
    // intervening rising edge acted on.
    bit rst_prev = 1'b0, start_prev = 1'b0, clr_prev = 1'b0, cont_prev = 1'b0;
    bit done_prev = 1'b0, valid_prev = 1'b0, hs_prev = 1'b0;
    logic [3:0]  sv_idx;
    logic [6:0]  sv_pc;
    logic [21:0] sv_st;
    logic [31:0] sv_gs;

    task automatic monitor_step();
        logic        hs;
        logic [63:0] fl;
        cyc++;
        hs = 1'b0;
        if (!rst_prev) begin
            m_mask  = '0;
            m_count = '0;
            m_busy  = 1'b0;
            exp_idx = 0;
            have_hs = 1'b0;
            check("rst_valid",   lane_err_valid,  0);
            check("rst_done",    scan_done,       0);
            check("rst_grp_sel", grp_sel,         0);
            check("rst_idx",     lane_err_idx,    0);
            check("rst_popcnt",  lane_err_popcnt, 0);
            check("rst_state",   lane_err_state,  0);
        end else begin
            if (start_prev && !m_busy)      m_busy = 1'b1;
            else if (done_prev && !cont_prev) m_busy = 1'b0;
            if (done_prev) begin
                if (m_count != {CW{1'b1}}) m_count = m_count + 1'b1;
                check("done_single_cycle", scan_done, 0);
            end
            if (clr_prev) m_mask = '0;
            if (hs_prev) begin
                check("valid_drop_after_ready", lane_err_valid, 0);
            end else if (valid_prev) begin
                check("stall_valid_hold", lane_err_valid, 1);
                check("stall_idx_hold",   lane_err_idx, sv_idx);
                check("stall_pc_hold",    lane_err_popcnt, sv_pc);
                check("stall_state_hold", lane_err_state, sv_st);
                check("stall_sel_hold",   grp_sel, sv_gs);
            end
            if (lane_err_valid && !valid_prev) begin
                if (exp_idx < W) begin
                    fl = lane_flags[exp_idx];
                    check("report_idx",     lane_err_idx, exp_idx);
                    check("report_popcnt",  lane_err_popcnt, $countones(fl));
                    check("report_state",   lane_err_state, lane_state[exp_idx]);
                    check("report_grp_sel", grp_sel, exp_idx);
                    if (fl != 0) m_mask[exp_idx] = 1'b1;
                end else begin
                    check("report_beyond_last_lane", exp_idx, W - 1);
                end
                if (have_hs) check("lane_latency", cyc - hs_cyc, S + 4);
            end
            if (lane_err_valid) begin
                sv_idx = lane_err_idx;
                sv_pc  = lane_err_popcnt;
                sv_st  = lane_err_state;
                sv_gs  = grp_sel;
            end
            hs = lane_err_valid && lane_err_ready;
            if (hs) begin
                exp_idx++;
                hs_cyc  = cyc;
                have_hs = 1'b1;
                n_reports++;
            end
            if (scan_done) begin
                check("done_after_all_lanes", exp_idx, W);
                exp_idx = 0;
                have_hs = 1'b0;
            end
        end
        check("mask",          err_lane_mask, m_mask);
        check("scan_count",    scan_count, m_count);
        check("scan_busy",     scan_busy, m_busy);
        check("grp_sel_range", grp_sel < W, 1);
        rst_prev   = rst_n;
        start_prev = scan_start;
        clr_prev   = clr_sticky;
        cont_prev  = scan_continuous;
        done_prev  = scan_done;
        valid_prev = lane_err_valid;
        hs_prev    = hs;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!scan_busy) break;
            tick();
        end
        check("wait_idle", scan_busy, 0);
    endtask

    task automatic wait_grp(input logic [31:0] v, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (grp_sel == v) break;
            tick();
        end
        check("wait_grp_sel", grp_sel, v);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (lane_err_valid) break;
            tick();
        end
        check("wait_valid", lane_err_valid, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (scan_done) break;
            tick();
        end
        check("wait_done", scan_done, 1);
        tick();
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            lane_flags[i] = '0;
            lane_state[i] = '0;
        end
    endtask

    function automatic logic [63:0] rand_flags();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = 64'd1 << $urandom_range(0, 63);
            2:       v = '1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    bit stop_rand = 1'b0;

    task automatic stimulus();
        int rep0;
        clear_tables();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("init_busy",    scan_busy, 0);
        check("init_grp_sel", grp_sel, 0);
        check("init_count",   scan_count, 0);

        // 1: all-clean scan
        rep0 = n_reports;
        pulse_start();
        wait_idle(200);
        check("t1_reports", n_reports - rep0, 4);
        check("t1_count",   scan_count, 16'd1);
        check("t1_mask",    err_lane_mask, 9'd0);
        check("t1_grp_hold", grp_sel, 32'd3);

        // 2: errors on lane 2
        lane_flags[2] = 64'h0000_0000_0000_00FF;
        lane_state[2] = 22'h155;
        pulse_start();
        wait_grp(32'd2, 100);
        wait_valid(20);
        check("t2_idx",    lane_err_idx, 4'd2);
        check("t2_popcnt", lane_err_popcnt, 7'd8);
        check("t2_state",  lane_err_state, 22'h155);
        wait_idle(200);
        check("t2_mask",   err_lane_mask, 9'b000000100);

        // 3: stall in lane 1 report
        pulse_start();
        wait_grp(32'd1, 100);
        lane_err_ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_valid", lane_err_valid, 1);
            check("t3_idx",   lane_err_idx, 4'd1);
            check("t3_sel",   grp_sel, 32'd1);
        end
        lane_err_ready = 1'b1;
        wait_idle(200);
        check("t3_count", scan_count, 16'd3);

        // 4: continuous mode, dropped during the third scan
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int l = 0; l < W; l++) begin
            lane_flags[l] = rand_flags();
            lane_state[l] = 22'($urandom);
        end
        lane_flags[1] = '1;
        scan_continuous = 1'b1;
        pulse_start();
        wait_done(200);
        wait_done(200);
        wait_grp(32'd1, 100);
        scan_continuous = 1'b0;
        pulse_start();
        wait_idle(200);
        check("t4_count", scan_count, 16'd3);
        repeat (10) tick();
        check("t4_no_restart", scan_busy, 0);

        // 5: clear coinciding with capture of lane 3
        clear_tables();
        lane_flags[0] = 64'h1;
        lane_flags[1] = 64'h3;
        lane_flags[3] = 64'hF0;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        pulse_start();
        wait_grp(32'd2, 100);
        wait_grp(32'd3, 100);
        repeat (S) tick();
        check("t5_mask_before", err_lane_mask, 9'b000000011);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("t5_valid",      lane_err_valid, 1);
        check("t5_mask_after", err_lane_mask, 9'b000001000);
        wait_idle(200);

        // 6: reset while a report is pending
        lane_flags[2] = 64'h8000_0000_0000_0001;
        pulse_start();
        wait_grp(32'd1, 100);
        wait_valid(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_valid", lane_err_valid, 0);
        check("t6_busy",  scan_busy, 0);
        check("t6_mask",  err_lane_mask, 9'd0);
        check("t6_sel",   grp_sel, 32'd0);
        rep0 = n_reports;
        pulse_start();
        wait_idle(200);
        check("t6_rescan_reports", n_reports - rep0, 4);

        // Randomized scans with random backpressure and sticky clears.
        for (int s = 0; s < 8; s++) begin
            for (int l = 0; l < W; l++) begin
                lane_flags[l] = rand_flags();
                lane_state[l] = 22'($urandom);
            end
            pulse_start();
            stop_rand = 1'b0;
            fork
                begin
                    while (!stop_rand) begin
                        lane_err_ready = 1'($urandom_range(0, 1));
                        clr_sticky     = ($urandom_range(0, 7) == 0);
                        tick();
                    end
                end
                begin
                    wait_idle(800);
                    stop_rand = 1'b1;
                end
            join
            lane_err_ready = 1'b1;
            clr_sticky     = 1'b0;
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            stimulus();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dqs_group_scan_ctrl.md
Name: dqs_group_scan_ctrl

Overview:
Scan sequencer that sits directly upstream of the DDR PHY per-lane debug group mux and drives its lane-select bus. It also consumes the mux's registered group outputs. It steps the select through every DQS lane, waits for the mux to settle, captures each lane's error flags and slice state, and counts error bits per lane. Per-lane results go out through a valid/ready report channel and a sticky per-lane error mask for the training/debug controller.

Parameters:
MEM_DQS_WIDTH, 4, number of DQS lanes scanned (1..9)
SETTLE_CYCLES, 2, cycles waited after a select change before capture (1..15; mux has 1-cycle registered latency)
CNT_WIDTH, 16, width of completed-scan counter

Ports:
ddrphy_sysclk  in  1  clock
ddrphy_rst_n  in  1  reset, synchronous, active-low
scan_start  in  1  single-cycle pulse, begin a scan
scan_continuous  in  1  level; when high, restart from lane 0 after each scan
clr_sticky  in  1  pulse, clear err_lane_mask
grp_sel  out  32  lane select to the group mux
err_flag_out_group  in  64  selected-lane error flags from the mux
dbg_slice_state_group  in  22  selected-lane slice state from the mux
scan_busy  out  1  high from leaving IDLE until return to IDLE
scan_done  out  1  single-cycle pulse at end of each full scan
lane_err_valid  out  1  report valid
lane_err_ready  in  1  report ready
lane_err_idx  out  4  lane index of the report
lane_err_popcnt  out  7  number of set bits in the captured err flags (0..64)
lane_err_state  out  22  captured slice state
err_lane_mask  out  9  sticky bit per lane with nonzero popcnt (bits >= MEM_DQS_WIDTH always 0)
scan_count  out  CNT_WIDTH  completed scans, saturating

Behaviour:
- Reset (ddrphy_rst_n low at a clock edge) forces all outputs to 0, the FSM to IDLE and the lane index to 0. This holds in any state, including mid-REPORT; a pending report is dropped.
- All outputs are registered.
- FSM states: IDLE, SEL, SETTLE, CAPTURE, REPORT, NEXT, DONE.
- IDLE:
  - scan_busy=0; grp_sel holds its last value.
  - scan_start=1 -> SEL with idx=0.
  - scan_start in any other state is ignored.
- SEL (1 cycle):
  - grp_sel <= {28'b0, idx}.
  - Settle counter <= SETTLE_CYCLES-1.
  - Next state is SETTLE.
- SETTLE:
  - Decrement the counter each cycle; at 0 go to CAPTURE.
  - Lasts exactly SETTLE_CYCLES cycles.
- CAPTURE (1 cycle):
  - lane_err_popcnt <= popcount(err_flag_out_group).
  - lane_err_state <= dbg_slice_state_group; lane_err_idx <= idx.
  - If popcount != 0, set err_lane_mask[idx].
  - Next state is REPORT.
- REPORT:
  - lane_err_valid=1.
  - Hold valid and all lane_err_* fields stable until lane_err_ready=1 at a clock edge, then drop valid and go to NEXT.
  - grp_sel stays unchanged while stalled.
- NEXT (1 cycle):
  - If idx == MEM_DQS_WIDTH-1, go to DONE.
  - Otherwise idx <= idx+1 and go to SEL.
- DONE (1 cycle):
  - scan_done=1 for exactly one cycle.
  - scan_count <= scan_count+1, saturating at all-ones.
  - If scan_continuous=1, idx <= 0 and go to SEL; otherwise go to IDLE.
  - scan_continuous is sampled only in DONE; dropping it mid-scan completes the current scan.
- Per-lane latency with ready held high is SETTLE_CYCLES+4 cycles.
- clr_sticky clears err_lane_mask in any state. If it coincides with a CAPTURE set, the set bit survives and the others clear.
- grp_sel never exceeds MEM_DQS_WIDTH-1.

Optional Feature:
SCAN_SKIP_CLEAN_EN
- Defined: in CAPTURE, a popcount of 0 goes straight to NEXT with no REPORT and no valid pulse. lane_err_* registers still update.
- Undefined: every lane is reported regardless of popcount.

Test Plan:
1. Defaults, all flags 0, pulse scan_start -> grp_sel steps 0,1,2,3; four reports with popcnt=0, idx 0..3; one scan_done; scan_count=1; mask=0; 6 cycles per lane with ready=1.
2. Lane 2 flags=64'h0000_0000_0000_00FF, state=22'h155 -> report idx=2, popcnt=8, state=22'h155; err_lane_mask=9'b000000100.
3. lane_err_ready low for 10 cycles in lane 1 REPORT -> valid stays high, fields and grp_sel=1 stable, next lane starts only after ready.
4. scan_continuous=1 for two scans, then dropped mid-third scan -> scan_count=3, then IDLE with scan_busy=0; scan_start during busy has no effect.
5. clr_sticky in the same cycle as CAPTURE setting lane 3, with mask previously 9'b000000011 -> mask=9'b000001000.
6. Reset asserted while valid=1 in REPORT -> next edge: valid=0, busy=0, mask=0, grp_sel=0, IDLE; a new scan_start scans from lane 0.
